// File: rtl/button_event_pkg.sv
// Shared types and helpers for button_event_queue: channel state encoding,
// pending-slot layout and event field layout {btn, double}.
package button_event_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_WAIT = 1'b1
  } chan_state_e;

  typedef struct packed {
    logic valid;
    logic dbl;
  } pend_t;

  // Queued event word is {btn, double}; double sits in the LSB.
  localparam int EVT_DBL_BIT = 0;
  localparam int EVT_BTN_LSB = 1;

  function automatic int btn_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int timer_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/tap_detector.sv
// One button channel: single/double tap classifier plus a one-entry pending slot.
// Tap classification exists only when BUTTON_EVENT_DOUBLE_TAP_EN is defined.
module tap_detector
  import button_event_pkg::*;
#(
  parameter int TAP_WINDOW_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse_i,
  input  logic        clear_i,
  output logic        pend_valid_o,
  output logic        pend_double_o,
  output logic        drop_o,
  output chan_state_e state_o
);

  if (TAP_WINDOW_CYCLES < 2) begin : g_bad_window
    $error("TAP_WINDOW_CYCLES must be at least 2");
  end

  logic  emit;
  logic  emit_dbl;
  pend_t pend_q, pend_d;

`ifdef BUTTON_EVENT_DOUBLE_TAP_EN
  localparam int TW = timer_width(TAP_WINDOW_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TAP_WINDOW_CYCLES - 1);

  chan_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    emit     = 1'b0;
    emit_dbl = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (pulse_i) begin
          state_d = CH_WAIT;
          timer_d = '0;
        end
      end
      CH_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A pulse on the expiry cycle still counts as the second tap.
        if (pulse_i) begin
          emit     = 1'b1;
          emit_dbl = 1'b1;
          state_d  = CH_IDLE;
          timer_d  = '0;
        end else if (timer_q == T_LAST) begin
          emit    = 1'b1;
          state_d = CH_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = CH_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign state_o = state_q;
`else
  assign emit     = pulse_i;
  assign emit_dbl = 1'b0;
  assign state_o  = CH_IDLE;
`endif

  // A new event only fits if the slot is empty or being drained this cycle.
  always_comb begin
    pend_d = pend_q;
    drop_o = 1'b0;
    if (clear_i) pend_d.valid = 1'b0;
    if (emit) begin
      if (pend_d.valid) begin
        drop_o = 1'b1;
      end else begin
        pend_d.valid = 1'b1;
        pend_d.dbl   = emit_dbl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend_valid_o  = pend_q.valid;
  assign pend_double_o = pend_q.dbl;

endmodule

// File: rtl/button_event_queue.sv
// Per-button tap classifiers feeding a fixed-priority arbiter and an event FIFO
// read via valid/ready. Double taps require BUTTON_EVENT_DOUBLE_TAP_EN.
module button_event_queue
  import button_event_pkg::*;
#(
  parameter  int SIGNAL_WIDTH      = 4,
  parameter  int TAP_WINDOW_CYCLES = 12_500_000,
  parameter  int FIFO_DEPTH        = 8,
  localparam int BW                = btn_width(SIGNAL_WIDTH),
  localparam int CW                = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIGNAL_WIDTH-1:0] press_pulse,
  output logic                    event_valid,
  input  logic                    event_ready,
  output logic [BW-1:0]           event_btn,
  output logic                    event_double,
  output logic [CW-1:0]           event_count,
  output logic                    overflow,
  output logic [SIGNAL_WIDTH-1:0] dbg_chan_wait
);

  // Handshake: an event leaves the FIFO on any rising edge where event_valid
  // and event_ready are both high; event_btn/event_double are stable while
  // event_valid is high and not popped.

  localparam int EW = BW + 1;
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [SIGNAL_WIDTH-1:0] pend_valid, pend_double, drop, sel, grant;

  for (genvar i = 0; i < SIGNAL_WIDTH; i++) begin : g_chan
    chan_state_e chan_state;
    tap_detector #(
      .TAP_WINDOW_CYCLES(TAP_WINDOW_CYCLES)
    ) u_tap (
      .clk          (clk),
      .rst          (rst),
      .pulse_i      (press_pulse[i]),
      .clear_i      (grant[i]),
      .pend_valid_o (pend_valid[i]),
      .pend_double_o(pend_double[i]),
      .drop_o       (drop[i]),
      .state_o      (chan_state)
    );
    assign dbg_chan_wait[i] = (chan_state == CH_WAIT);
  end

  logic [BW-1:0] sel_idx;
  logic          sel_dbl;
  logic          any_pend;

  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    sel      = '0;
    sel_idx  = '0;
    sel_dbl  = 1'b0;
    any_pend = 1'b0;
    for (int i = SIGNAL_WIDTH - 1; i >= 0; i--) begin
      if (pend_valid[i]) begin
        sel      = '0;
        sel[i]   = 1'b1;
        sel_idx  = BW'(i);
        sel_dbl  = pend_double[i];
        any_pend = 1'b1;
      end
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, pop, push;
  logic [EW-1:0] head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = event_valid && event_ready;
  assign push  = any_pend && (!full || pop);
  assign grant = push ? sel : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (|drop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked by event_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sel_idx, sel_dbl};
  end

  assign head        = mem_q[rd_ptr_q];
  assign event_valid = (count_q != '0);
  assign event_count = count_q;
  assign overflow    = overflow_q;
  assign event_btn   = event_valid ? head[EW-1:EVT_BTN_LSB] : '0;
`ifdef BUTTON_EVENT_DOUBLE_TAP_EN
  assign event_double = event_valid ? head[EVT_DBL_BIT] : 1'b0;
`else
  assign event_double = 1'b0;
`endif

endmodule

// File: doc/button_event_queue.md
# button_event_queue

Downstream consumer of the button synchronize/debounce/edge-detect chain. Takes one single-cycle press pulse per button, classifies each press as a single or double tap within a programmable window, and queues the resulting events in a small FIFO. Top-level FSMs read the events through a valid/ready handshake.

## Interface
- SIGNAL_WIDTH, 4: number of button channels, ≥1.
- TAP_WINDOW_CYCLES, 12_500_000: double-tap window in clk cycles, ≥2.
- FIFO_DEPTH, 8: event queue depth, power of two, ≥2.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- press_pulse  in  SIGNAL_WIDTH  one-cycle press pulses from the edge detector, one bit per button.
- event_valid  out  1  FIFO non-empty.
- event_ready  in  1  consumer accepts the head event when high together with event_valid.
- event_btn  out  max(1,$clog2(SIGNAL_WIDTH))  button index of the head event; 0 when empty.
- event_double  out  1  head event is a double tap; 0 when empty.
- event_count  out  $clog2(FIFO_DEPTH+1)  number of queued events.
- overflow  out  1  sticky flag; set when an event is dropped; cleared only by rst.

## Operation
- Each channel has an FSM with two states and a timer sized for TAP_WINDOW_CYCLES.
  - IDLE: on a pulse, go to WAIT and load timer=0.
  - WAIT: the timer increments each cycle.
  - WAIT, pulse: emit DOUBLE and go to IDLE.
  - WAIT, timer==TAP_WINDOW_CYCLES-1 with no pulse: emit SINGLE and go to IDLE.
  - WAIT, pulse in the same cycle the timer expires: the pulse wins and DOUBLE is emitted.
- An emitted event is registered into the channel's pending slot (one entry: a valid bit and a double bit).
- Arbiter: each cycle, the lowest-index channel with pending set is pushed into the FIFO when push is allowed. Only that channel's pending slot is cleared.
- Push is allowed when the FIFO is not full, or when a pop happens in the same cycle.
- Pop: event_valid && event_ready.
- A simultaneous push and pop leaves the count unchanged.
- A channel that emits while its pending slot is still set and not being cleared that cycle drops the new event and sets overflow. The pending event is kept.
- Reset, asynchronous: all FSMs go to IDLE, timers 0, pending slots cleared, FIFO empty. All outputs are 0. Any open tap window is discarded without an event.

## Timing
- Let t be the cycle of a first pulse, with W=TAP_WINDOW_CYCLES.
- WAIT spans cycles t+1 through t+W.
- A second pulse in cycles t+1..t+W produces a DOUBLE.
- With no second pulse, SINGLE pending is visible at t+W+1.
- Double: a second pulse at cycle p gives pending at p+1.
- Pending→FIFO latency is 1 cycle. With an empty FIFO and no contention, event_valid rises at pending+1:
  - single: t+W+2
  - double: p+2
- A pulse at t+W+1 or later starts a new window.
- Event order out of the FIFO: push order. Ties are resolved lowest index first, one event per cycle.

## Configuration
- BUTTON_EVENT_DOUBLE_TAP_EN defined: behaviour as above.
- BUTTON_EVENT_DOUBLE_TAP_EN undefined:
  - no timers and no WAIT state
  - every pulse immediately emits SINGLE (pending at t+1, event_valid at t+2)
  - event_double is tied to 0
  - TAP_WINDOW_CYCLES is ignored

## Structure
- Shared package button_event_pkg holds:
  - channel state encoding (IDLE, WAIT)
  - event field layout: {btn, double}
  - derived width constants
- Sub-module tap_detector contains one channel FSM, its timer and its pending slot. It is instantiated SIGNAL_WIDTH times in a generate loop.
- The arbiter and FIFO live in the top level.

## Test plan
- W=16, event_ready=1, pulse ch0 at cycle 10 -> event_valid at 28, btn=0, double=0. No further events.
- Pulses ch2 at 10 and 20 -> event_valid at 22, btn=2, double=1. No trailing single.
- Window boundary:
  - pulses ch1 at 10 and 26 -> one double.
  - pulses ch1 at 10 and 27 -> single at 28, then a single for the second press at 45.
- ch1 and ch3 expire in the same cycle -> ch1 event, then ch3 event on consecutive cycles. overflow=0.
- Backpressure with event_ready=0, DEPTH=8: ten spaced singles on ch0 -> event_count=8, one held pending, the tenth dropped, overflow=1. Raising ready drains exactly 9 events in order.
- Reset:
  - rst during an open window -> no event, all outputs 0.
  - With the macro undefined, a pulse at 10 -> event_valid at 12 with double=0.
